// File: rtl/instr_encoder.sv
// Purpose: packs field-level commands into RV32I R/load/store/branch words and streams them to imem.
// Latency: a word accepted at edge N shows up on instr_valid after that edge when the FIFO was empty.
// Backpressure: cmd_ready is !full from registered state only; instr_ready never reaches cmd_ready.

// Purpose: generic synchronous FIFO with wrap-bit pointers and a registered array.
// Latency: a pushed word is visible at head_dat after the push edge.
// Backpressure: caller pushes only when !full and pops only when !empty.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // Entries are not wiped on clr, so the head keeps the last popped word when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_vld) begin
        mem_d[wr_ptr_q[PW-1:0]] = push_dat;
        wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      end
      if (pop_rdy) begin
        rd_ptr_d = rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[PW-1:0]];
endmodule

// Purpose: RV32I word assembler feeding the instruction-memory programming port.
// Latency: one cycle from command accept to instr_valid (empty FIFO).
// Backpressure: cmd_ready = !full && !clear; misaligned branches are consumed and dropped.
module instr_encoder #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            DEPTH     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_type,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [12:0]   imm,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr_data,
  output logic [AW-1:0] instr_addr,
  output logic          err,
  output logic [15:0]   count
);
  localparam logic [1:0] CMD_R  = 2'b00;
  localparam logic [1:0] CMD_LD = 2'b01;
  localparam logic [1:0] CMD_ST = 2'b10;
  localparam logic [1:0] CMD_BR = 2'b11;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic [31:0]   enc_dat;
  logic          misalign;
  logic          accept;
  logic          push_vld;
  logic          pop_rdy;
  logic          fifo_full;
  logic          fifo_empty;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   count_q, count_d;

  always_comb begin
    enc_dat = '0;
    unique case (cmd_type)
      CMD_R:  enc_dat = {funct7, rs2, rs1, funct3, rd, OP_R};
      CMD_LD: enc_dat = {imm[11:0], rs1, funct3, rd, OP_LD};
      CMD_ST: enc_dat = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_ST};
      CMD_BR: enc_dat = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BR};
      default: enc_dat = '0;
    endcase
  end

  // clear blocks the handshake outright, which also gives it priority over push and err.
  assign cmd_ready = !fifo_full && !clear;
  assign accept    = cmd_valid && cmd_ready;
  assign misalign  = (cmd_type == CMD_BR) && imm[0];
  assign push_vld  = accept && !misalign;
  assign pop_rdy   = instr_valid && instr_ready && !clear;

  always_comb begin
    err_d   = accept && misalign;
    addr_d  = addr_q;
    count_d = count_q;
    if (clear) begin
      addr_d  = BASE_ADDR;
      count_d = '0;
    end else if (pop_rdy) begin
      addr_d  = addr_q + AW'(4);
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
    end else begin
      err_q   <= err_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clear),
    .push_vld (push_vld),
    .push_dat (enc_dat),
    .pop_rdy  (pop_rdy),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (instr_data)
  );

  assign instr_valid = !fifo_empty;
  assign instr_addr  = addr_q;
  assign err         = err_q;
  assign count       = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table for encodings plus hand sequences for
// backpressure, streaming, clear and asynchronous reset.
module tb_instr_encoder;
  localparam int AW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [12:0]   imm = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr_data;
  logic [AW-1:0] instr_addr;
  logic          err;
  logic [15:0]   count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_addr = '0;
  logic [15:0] exp_count = '0;

  instr_encoder #(.AW(AW), .BASE_ADDR('0), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_type    (cmd_type),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct3      (funct3),
    .funct7      (funct7),
    .imm         (imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_addr  (instr_addr),
    .err         (err),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [12:0] imm;
    logic [31:0] word;
    logic        bad;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] ty, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [12:0] im);
    cmd_type  = ty;
    rd        = d;
    rs1       = s1;
    rs2       = s2;
    funct3    = f3;
    funct7    = f7;
    imm       = im;
    cmd_valid = 1'b1;
  endtask

  // R-type with only rd set: word = (rd << 7) | 0x33
  function automatic logic [31:0] r_rd_word(input int r);
    return (32'(r) << 7) | 32'h33;
  endfunction

  initial begin
    vecs[0] = '{2'b00, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 13'h0000, 32'h002081B3, 1'b0};
    vecs[1] = '{2'b01, 5'd5,  5'd2,  5'd0,  3'd2, 7'h00, 13'h0008, 32'h00812283, 1'b0};
    vecs[2] = '{2'b10, 5'd0,  5'd2,  5'd6,  3'd2, 7'h00, 13'h000C, 32'h00612623, 1'b0};
    vecs[3] = '{2'b11, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 13'h1FFC, 32'hFE208EE3, 1'b0};
    vecs[4] = '{2'b11, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 13'h0005, 32'h00000000, 1'b1};
    vecs[5] = '{2'b00, 5'd10, 5'd11, 5'd12, 3'd0, 7'h20, 13'h0000, 32'h40C58533, 1'b0};
    vecs[6] = '{2'b01, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 13'h1FFF, 32'hFFF00083, 1'b0};
    vecs[7] = '{2'b10, 5'd31, 5'd2,  5'd1,  3'd0, 7'h55, 13'h1FFF, 32'hFE110FA3, 1'b0};
    vecs[8] = '{2'b11, 5'd9,  5'd3,  5'd4,  3'd1, 7'h11, 13'h0800, 32'h004190E3, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data", instr_data, 0);
    chk("rst_addr", instr_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 9; i++) begin
      drive_cmd(vecs[i].ty, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (vecs[i].bad) begin
        chk($sformatf("err_pulse[%0d]", i), err, 1);
        chk($sformatf("no_word[%0d]", i), instr_valid, 0);
        @(negedge clk);
        chk($sformatf("err_one_cycle[%0d]", i), err, 0);
        chk($sformatf("count_kept[%0d]", i), count, exp_count);
      end else begin
        chk($sformatf("valid[%0d]", i), instr_valid, 1);
        chk($sformatf("data[%0d]", i), instr_data, vecs[i].word);
        chk($sformatf("addr[%0d]", i), instr_addr, exp_addr);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        exp_addr  = exp_addr + 4;
        exp_count = exp_count + 1;
        chk($sformatf("count[%0d]", i), count, exp_count);
        chk($sformatf("addr_inc[%0d]", i), instr_addr, exp_addr);
        chk($sformatf("drained[%0d]", i), instr_valid, 0);
      end
    end

    // Fill with the sink stalled, then drain.
    drive_cmd(2'b00, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    @(negedge clk);
    drive_cmd(2'b00, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_head", instr_data, r_rd_word(7));
    chk("full_addr", instr_addr, exp_addr);
    drive_cmd(2'b00, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    @(negedge clk);
    chk("stall_cmd_ready", cmd_ready, 0);
    chk("stall_head", instr_data, r_rd_word(7));
    chk("stall_addr", instr_addr, exp_addr);
    cmd_valid   = 1'b0;
    instr_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("drain_valid[%0d]", j), instr_valid, 1);
      chk($sformatf("drain_data[%0d]", j), instr_data, r_rd_word(7 + j));
      chk($sformatf("drain_addr[%0d]", j), instr_addr, exp_addr);
      @(negedge clk);
      exp_addr  = exp_addr + 4;
      exp_count = exp_count + 1;
    end
    instr_ready = 1'b0;
    chk("drain_empty", instr_valid, 0);
    chk("drain_cmd_ready", cmd_ready, 1);
    chk("drain_count", count, exp_count);

    // One entry resident, push and pop every cycle.
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        chk($sformatf("stream_valid[%0d]", i - 1), instr_valid, 1);
        chk($sformatf("stream_data[%0d]", i - 1), instr_data, r_rd_word(i + 9));
        chk($sformatf("stream_addr[%0d]", i - 1), instr_addr, exp_addr);
        chk($sformatf("stream_cmd_ready[%0d]", i - 1), cmd_ready, 1);
        exp_addr  = exp_addr + 4;
        exp_count = exp_count + 1;
      end
      drive_cmd(2'b00, 5'(i + 10), 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
      @(negedge clk);
    end
    chk("stream_data[9]", instr_data, r_rd_word(19));
    chk("stream_addr[9]", instr_addr, exp_addr);
    chk("stream_count", count, exp_count);

    // clear wins over the pending command and the pop.
    drive_cmd(2'b00, 5'd20, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    clear = 1'b1;
    #1;
    chk("clear_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    clear       = 1'b0;
    cmd_valid   = 1'b0;
    instr_ready = 1'b0;
    exp_addr    = '0;
    exp_count   = '0;
    chk("clear_valid", instr_valid, 0);
    chk("clear_addr", instr_addr, 0);
    chk("clear_count", count, 0);

    drive_cmd(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    @(negedge clk);
    chk("post_clear_data", instr_data, r_rd_word(1));
    chk("post_clear_addr", instr_addr, 0);
    drive_cmd(2'b00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    @(negedge clk);
    cmd_valid   = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("mid_drain_count", count, 1);
    chk("mid_drain_valid", instr_valid, 1);

    // Asynchronous reset between clock edges.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_data", instr_data, 0);
    chk("arst_addr", instr_addr, 0);
    chk("arst_count", count, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    instr_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Assembles RV32I machine words from field-level commands for the four instruction classes the core's main decoder supports: R-type ALU, load, store and branch.
- Buffers the assembled words in a small FIFO and streams them to the instruction-memory programming port with a valid/ready handshake and an auto-incrementing byte address.
- Used by the test harness and boot loader to build programs that the core's decode stage then consumes.

Parameters:
- AW, 32, width of the instruction-memory byte address.
- BASE_ADDR, 0, first address emitted after reset or clear; must be 4-byte aligned.
- DEPTH, 2, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: empties FIFO, address returns to BASE_ADDR
- cmd_valid  in  1  command present
- cmd_ready  out  1  encoder can accept a command
- cmd_type  in  2  00 R-type, 01 load, 10 store, 11 branch
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R-type only)
- imm  in  13  signed immediate; bits [11:0] used for load/store, [12:1] for branch
- instr_valid  out  1  instr_data/instr_addr valid
- instr_ready  in  1  memory accepts the word
- instr_data  out  32  encoded instruction
- instr_addr  out  AW  byte address for instr_data
- err  out  1  one-cycle pulse: branch command rejected
- count  out  16  words emitted since reset/clear; wraps at 2^16

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; instr_valid=0, instr_data=0.
  - instr_addr=BASE_ADDR, count=0, err=0.
  - cmd_ready=1 once reset is released.
- Command accept and push:
  - Accept occurs when cmd_valid & cmd_ready at a rising edge.
  - The encoded word is pushed into the FIFO the same edge.
  - cmd_ready = !full, registered-state only; there is no combinational path from instr_ready.
- Encoding (opcode in [6:0]):
  - R: opcode 0110011; word = {funct7, rs2, rs1, funct3, rd, op}.
  - Load: opcode 0000011; word = {imm[11:0], rs1, funct3, rd, op}. rs2, funct7 and imm[12] are ignored.
  - Store: opcode 0100011; word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op}. rd and funct7 are ignored.
  - Branch: opcode 1100011; word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}. rd and funct7 are ignored.
- Branch misalignment:
  - A branch with imm[0]=1 is accepted (handshake completes) but not pushed.
  - err pulses high the following cycle; count and the FIFO are unchanged.
- Output:
  - instr_valid = FIFO non-empty; instr_data = FIFO head.
  - instr_data and instr_addr are held stable while instr_valid & !instr_ready.
  - On instr_valid & instr_ready: pop, instr_addr += 4 (wraps modulo 2^AW), count += 1.
- Latency: a word accepted at edge N is visible on instr_valid/instr_data after edge N (one cycle) when the FIFO was empty.
- Simultaneous push and pop:
  - When not full, both occur; occupancy is unchanged.
  - When full, cmd_ready=0, so no push occurs.
- Empty: instr_data holds the last popped value (0 after reset); it is don't-care for checking.
- clear:
  - Has priority over push, pop and err in the same cycle.
  - The command presented that cycle is not accepted (cmd_ready is forced 0 during clear).
  - Afterwards: FIFO empty, instr_addr=BASE_ADDR, count=0.
- Reset mid-stream: buffered words are discarded; the same state as power-on reset.

Test Plan:
- After reset, R add x3,x1,x2 (funct7=0, funct3=0) -> next cycle instr_valid=1, instr_data=0x002081B3, instr_addr=0x0; with instr_ready=1, count=1 and instr_addr=0x4.
- Load rd=5, rs1=2, funct3=2, imm=8 -> 0x00812283. Store rs2=6, rs1=2, funct3=2, imm=12 -> 0x00612623. Check both at consecutive addresses.
- Branch rs1=1, rs2=2, funct3=0, imm=-4 (0x1FFC) -> 0xFE208EE3. Same command with imm=0x0005 -> err pulse, no word emitted, count unchanged.
- Hold instr_ready=0 and push DEPTH commands -> cmd_ready falls to 0 and instr_data stays stable. Release instr_ready -> words drain in order at +4 addresses and cmd_ready returns to 1.
- Simultaneous push/pop with 1 entry for 10 cycles -> occupancy constant, 10 words in order with no gaps. Then assert clear with cmd_valid=1 -> command not accepted, FIFO empty, instr_addr=BASE_ADDR, count=0.
- Assert rst_n low mid-drain -> outputs reach reset values immediately (asynchronously, without a clock edge).
